// File: rtl/rle1_pkg.sv
// Shared definitions for the RLE1 encoder frame scheduler.
package rle1_pkg;

  // Width of one input symbol presented to the encoder
  localparam int SYM_W = 2;

  // Width of one encoded output token
  localparam int TOK_W = 6;

  // Reserved symbol used to close a frame
  localparam logic [SYM_W-1:0] DELIM_DEFAULT = 2'b11;

  // Scheduler phases: arbitration, data passthrough, delimiter injection
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_STREAM = 2'b01,
    ST_DELIM  = 2'b10
  } state_t;

endpackage

// File: rtl/rle1_rr_pick.sv
// Combinational round-robin selector: searches grant+1, grant+2, ...
// (mod NREQ) and returns the first requester with valid asserted.
module rle1_rr_pick
  import rle1_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req_vld,
  input  logic [1:0]      last_grant,
  output logic [1:0]      next_grant,
  output logic            any_vld
);

  // Walk the rotation order once; the first valid requester wins
  always_comb begin
    next_grant = last_grant;
    any_vld    = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        logic hit_s;
        hit_s      = !any_vld && req_vld[j] &&
                     (j == ((int'(last_grant) + k) % NREQ));
        next_grant = hit_s ? 2'(j) : next_grant;
        any_vld    = any_vld | hit_s;
      end
    end
  end

endmodule

// File: rtl/rle1_enc_sched.sv
// Round-robin frame scheduler in front of a shared rle1_enc input port.
// A granted producer streams FRAME_LEN symbols straight through to the
// encoder, then one delimiter symbol closes the run and marks the frame.
module rle1_enc_sched
  import rle1_pkg::*;
#(
  parameter int               NREQ      = 2,
  parameter int               FRAME_LEN = 16,
  parameter logic [SYM_W-1:0] DELIM     = DELIM_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [SYM_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]       req_vld,
  output logic [NREQ-1:0]       req_rdy,
  output logic [SYM_W-1:0]      enc_in,
  output logic                  enc_in_vld,
  input  logic                  enc_in_rdy,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic [15:0]           frames_done,
  output logic                  proto_err
);

  localparam int CNT_W = (FRAME_LEN <= 2) ? 1 : $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [1:0]         grant_r;
  logic [CNT_W-1:0]   sym_cnt_r;
  logic [15:0]        frames_done_r;
  logic               proto_err_r;

  logic [1:0]         pick_grant_s;
  logic               pick_any_s;
  logic [SYM_W-1:0]   g_data_s;
  logic               g_vld_s;
  logic               xfer_s;

  rle1_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req_vld    (req_vld),
    .last_grant (grant_r),
    .next_grant (pick_grant_s),
    .any_vld    (pick_any_s)
  );

  // Select the granted producer's symbol and valid
  always_comb begin
    g_data_s = {SYM_W{1'b0}};
    g_vld_s  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      g_data_s = (grant_r == 2'(i)) ? req_data[SYM_W*i +: SYM_W] : g_data_s;
      g_vld_s  = (grant_r == 2'(i)) ? req_vld[i] : g_vld_s;
    end
  end

  // Next-state and handshake outputs for the three scheduler phases
  always_comb begin
    state_nxt_s = state_r;
    enc_in      = {SYM_W{1'b0}};
    enc_in_vld  = 1'b0;
    req_rdy     = {NREQ{1'b0}};
    xfer_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable && pick_any_s) begin
          state_nxt_s = ST_STREAM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        enc_in     = g_data_s;
        enc_in_vld = g_vld_s;
        for (int i = 0; i < NREQ; i++) begin
          req_rdy[i] = (grant_r == 2'(i)) & enc_in_rdy;
        end
        xfer_s = g_vld_s & enc_in_rdy;
        if (xfer_s && (sym_cnt_r == LAST_CNT)) begin
          state_nxt_s = ST_DELIM;
        end else begin
          state_nxt_s = ST_STREAM;
        end
      end
      ST_DELIM: begin
        // Constant delimiter keeps enc_in stable across a stall
        enc_in     = DELIM;
        enc_in_vld = 1'b1;
        if (enc_in_rdy) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DELIM;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register; reset drops any frame in flight without a delimiter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Grant, symbol counter, frame counter and sticky protocol error
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_r       <= 2'(NREQ - 1);
      sym_cnt_r     <= {CNT_W{1'b0}};
      frames_done_r <= 16'd0;
      proto_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enable && pick_any_s) begin
            grant_r   <= pick_grant_s;
            sym_cnt_r <= {CNT_W{1'b0}};
          end
        end
        ST_STREAM: begin
          if (xfer_s) begin
            sym_cnt_r <= (sym_cnt_r == LAST_CNT) ? {CNT_W{1'b0}}
                                                 : sym_cnt_r + 1'b1;
            if (g_data_s == DELIM) begin
              proto_err_r <= 1'b1;
            end
          end
        end
        ST_DELIM: begin
          if (enc_in_rdy) begin
            frames_done_r <= frames_done_r + 16'd1;
          end
        end
        default: begin
          sym_cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign grant       = grant_r;
  assign busy        = (state_r != ST_IDLE);
  assign frames_done = frames_done_r;
  assign proto_err   = proto_err_r;

endmodule

// File: tb/tb_rle1_enc_sched.sv
// Self-checking bench for rle1_enc_sched (NREQ=2, FRAME_LEN=4): a vector
// table, directed multi-cycle sequences and a randomized run against a
// transaction-level reference model.
module tb_rle1_enc_sched;

  localparam int NREQ = 2;
  localparam int FLEN = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  req_data = 4'b0000;
  logic [1:0]  req_vld = 2'b00;
  logic [1:0]  req_rdy;
  logic [1:0]  enc_in;
  logic        enc_in_vld;
  logic        enc_in_rdy = 1'b0;
  logic [1:0]  grant;
  logic        busy;
  logic [15:0] frames_done;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic [1:0]  vld;
    logic [3:0]  data;
    logic        rdy;
    logic [1:0]  e_enc;
    logic        e_vld;
    logic [1:0]  e_rdy;
    logic        e_busy;
    logic [1:0]  e_gnt;
    logic [15:0] e_fr;
  } vec_t;

  vec_t tbl [7];

  rle1_enc_sched #(
    .NREQ      (NREQ),
    .FRAME_LEN (FLEN),
    .DELIM     (2'b11)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .req_data    (req_data),
    .req_vld     (req_vld),
    .req_rdy     (req_rdy),
    .enc_in      (enc_in),
    .enc_in_vld  (enc_in_vld),
    .enc_in_rdy  (enc_in_rdy),
    .grant       (grant),
    .busy        (busy),
    .frames_done (frames_done),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] e_enc,
                         input logic e_vld, input logic [1:0] e_rdy,
                         input logic e_busy, input logic [1:0] e_gnt,
                         input logic [15:0] e_fr, input logic e_perr);
    check({tag, ".enc_in"},      int'(enc_in),      int'(e_enc));
    check({tag, ".enc_in_vld"},  int'(enc_in_vld),  int'(e_vld));
    check({tag, ".req_rdy"},     int'(req_rdy),     int'(e_rdy));
    check({tag, ".busy"},        int'(busy),        int'(e_busy));
    check({tag, ".grant"},       int'(grant),       int'(e_gnt));
    check({tag, ".frames_done"}, int'(frames_done), int'(e_fr));
    check({tag, ".proto_err"},   int'(proto_err),   int'(e_perr));
  endtask

  // Apply inputs just after the rising edge, return at the falling edge
  task automatic drive(input logic r, input logic en, input logic [1:0] v,
                       input logic [3:0] d, input logic rd);
    @(posedge clk);
    #1;
    reset      = r;
    enable     = en;
    req_vld    = v;
    req_data   = d;
    enc_in_rdy = rd;
    #4;
  endtask

  // Reference model state for the randomized run
  int         owner;
  int         sent;
  int         m_last;
  int         m_frames;
  bit         m_perr;
  bit         p_vld [NREQ];
  logic [1:0] p_sym [NREQ];
  bit         acc   [NREQ];
  bit         en_r;
  bit         rdy_r;

  function automatic logic [1:0] rand_sym();
    logic [1:0] s;
    s = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    return s;
  endfunction

  initial begin
    // Single frame from producer 0, producer 1 idle with data 3 on its bus
    tbl[0] = '{1'b1, 2'b01, 4'b1100, 1'b1, 2'd0, 1'b0, 2'b00, 1'b0, 2'd1, 16'd0};
    tbl[1] = '{1'b1, 2'b01, 4'b1100, 1'b1, 2'd0, 1'b1, 2'b01, 1'b1, 2'd0, 16'd0};
    tbl[2] = '{1'b1, 2'b01, 4'b1100, 1'b1, 2'd0, 1'b1, 2'b01, 1'b1, 2'd0, 16'd0};
    tbl[3] = '{1'b1, 2'b01, 4'b1101, 1'b1, 2'd1, 1'b1, 2'b01, 1'b1, 2'd0, 16'd0};
    tbl[4] = '{1'b1, 2'b01, 4'b1110, 1'b1, 2'd2, 1'b1, 2'b01, 1'b1, 2'd0, 16'd0};
    tbl[5] = '{1'b1, 2'b00, 4'b1100, 1'b1, 2'd3, 1'b1, 2'b00, 1'b1, 2'd0, 16'd0};
    tbl[6] = '{1'b1, 2'b00, 4'b1100, 1'b1, 2'd0, 1'b0, 2'b00, 1'b0, 2'd0, 16'd1};

    // Reset state
    drive(1'b1, 1'b1, 2'b00, 4'b0000, 1'b1);
    drive(1'b1, 1'b1, 2'b00, 4'b0000, 1'b1);
    chk_out("reset", 2'd0, 1'b0, 2'b00, 1'b0, 2'd1, 16'd0, 1'b0);

    for (int i = 0; i < 7; i++) begin
      drive(1'b0, tbl[i].en, tbl[i].vld, tbl[i].data, tbl[i].rdy);
      chk_out($sformatf("tbl%0d", i), tbl[i].e_enc, tbl[i].e_vld,
              tbl[i].e_rdy, tbl[i].e_busy, tbl[i].e_gnt, tbl[i].e_fr, 1'b0);
    end

    // Backpressure during STREAM and DELIM on a producer-1 frame
    drive(1'b0, 1'b1, 2'b10, 4'b0100, 1'b1);
    chk_out("a_idle", 2'd0, 1'b0, 2'b00, 1'b0, 2'd0, 16'd1, 1'b0);
    drive(1'b0, 1'b1, 2'b10, 4'b0100, 1'b1);
    chk_out("a_s1", 2'd1, 1'b1, 2'b10, 1'b1, 2'd1, 16'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 2'b10, 4'b1000, 1'b0);
      chk_out("a_stall", 2'd2, 1'b1, 2'b00, 1'b1, 2'd1, 16'd1, 1'b0);
    end
    drive(1'b0, 1'b1, 2'b10, 4'b1000, 1'b1);
    chk_out("a_s2", 2'd2, 1'b1, 2'b10, 1'b1, 2'd1, 16'd1, 1'b0);
    drive(1'b0, 1'b1, 2'b10, 4'b0000, 1'b1);
    chk_out("a_s3", 2'd0, 1'b1, 2'b10, 1'b1, 2'd1, 16'd1, 1'b0);
    drive(1'b0, 1'b1, 2'b10, 4'b0100, 1'b1);
    chk_out("a_s4", 2'd1, 1'b1, 2'b10, 1'b1, 2'd1, 16'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 2'b00, 4'b0000, 1'b0);
      chk_out("a_dstall", 2'd3, 1'b1, 2'b00, 1'b1, 2'd1, 16'd1, 1'b0);
    end
    drive(1'b0, 1'b1, 2'b00, 4'b0000, 1'b1);
    chk_out("a_delim", 2'd3, 1'b1, 2'b00, 1'b1, 2'd1, 16'd1, 1'b0);
    drive(1'b0, 1'b1, 2'b00, 4'b0000, 1'b1);
    chk_out("a_idle2", 2'd0, 1'b0, 2'b00, 1'b0, 2'd1, 16'd2, 1'b0);

    // Enable dropped mid-frame: frame completes, no new grant until re-enabled
    drive(1'b0, 1'b1, 2'b11, 4'b0000, 1'b1);
    chk_out("b_idle", 2'd0, 1'b0, 2'b00, 1'b0, 2'd1, 16'd2, 1'b0);
    drive(1'b0, 1'b1, 2'b11, 4'b0000, 1'b1);
    chk_out("b_s1", 2'd0, 1'b1, 2'b01, 1'b1, 2'd0, 16'd2, 1'b0);
    drive(1'b0, 1'b1, 2'b11, 4'b0000, 1'b1);
    chk_out("b_s2", 2'd0, 1'b1, 2'b01, 1'b1, 2'd0, 16'd2, 1'b0);
    drive(1'b0, 1'b0, 2'b11, 4'b0000, 1'b1);
    chk_out("b_s3", 2'd0, 1'b1, 2'b01, 1'b1, 2'd0, 16'd2, 1'b0);
    drive(1'b0, 1'b0, 2'b11, 4'b0000, 1'b1);
    chk_out("b_s4", 2'd0, 1'b1, 2'b01, 1'b1, 2'd0, 16'd2, 1'b0);
    drive(1'b0, 1'b0, 2'b11, 4'b0000, 1'b1);
    chk_out("b_delim", 2'd3, 1'b1, 2'b00, 1'b1, 2'd0, 16'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 2'b11, 4'b0000, 1'b1);
      chk_out("b_hold", 2'd0, 1'b0, 2'b00, 1'b0, 2'd0, 16'd3, 1'b0);
    end
    drive(1'b0, 1'b1, 2'b11, 4'b0000, 1'b1);
    chk_out("b_reen", 2'd0, 1'b0, 2'b00, 1'b0, 2'd0, 16'd3, 1'b0);

    // Producer 1 sends the delimiter value mid-frame
    drive(1'b0, 1'b1, 2'b11, 4'b0000, 1'b1);
    chk_out("c_s1", 2'd0, 1'b1, 2'b10, 1'b1, 2'd1, 16'd3, 1'b0);
    drive(1'b0, 1'b1, 2'b11, 4'b1100, 1'b1);
    chk_out("c_s2", 2'd3, 1'b1, 2'b10, 1'b1, 2'd1, 16'd3, 1'b0);
    drive(1'b0, 1'b1, 2'b11, 4'b0100, 1'b1);
    chk_out("c_s3", 2'd1, 1'b1, 2'b10, 1'b1, 2'd1, 16'd3, 1'b1);
    drive(1'b0, 1'b1, 2'b11, 4'b1000, 1'b1);
    chk_out("c_s4", 2'd2, 1'b1, 2'b10, 1'b1, 2'd1, 16'd3, 1'b1);
    drive(1'b0, 1'b1, 2'b00, 4'b0000, 1'b1);
    chk_out("c_delim", 2'd3, 1'b1, 2'b00, 1'b1, 2'd1, 16'd3, 1'b1);
    drive(1'b0, 1'b1, 2'b00, 4'b0000, 1'b1);
    chk_out("c_idle", 2'd0, 1'b0, 2'b00, 1'b0, 2'd1, 16'd4, 1'b1);

    // Reset after the second transfer aborts the frame
    drive(1'b0, 1'b1, 2'b01, 4'b0000, 1'b1);
    chk_out("d_idle", 2'd0, 1'b0, 2'b00, 1'b0, 2'd1, 16'd4, 1'b1);
    drive(1'b0, 1'b1, 2'b01, 4'b0000, 1'b1);
    chk_out("d_s1", 2'd0, 1'b1, 2'b01, 1'b1, 2'd0, 16'd4, 1'b1);
    drive(1'b0, 1'b1, 2'b01, 4'b0000, 1'b1);
    chk_out("d_s2", 2'd0, 1'b1, 2'b01, 1'b1, 2'd0, 16'd4, 1'b1);
    drive(1'b1, 1'b1, 2'b01, 4'b0000, 1'b1);
    chk_out("d_rstcyc", 2'd0, 1'b1, 2'b01, 1'b1, 2'd0, 16'd4, 1'b1);
    drive(1'b0, 1'b1, 2'b00, 4'b0000, 1'b1);
    chk_out("d_rst", 2'd0, 1'b0, 2'b00, 1'b0, 2'd1, 16'd0, 1'b0);

    // Randomized traffic against the reference model
    owner    = -1;
    sent     = 0;
    m_last   = 1;
    m_frames = 0;
    m_perr   = 1'b0;
    for (int p = 0; p < NREQ; p++) begin
      p_vld[p] = ($urandom_range(0, 9) < 7);
      p_sym[p] = rand_sym();
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [1:0] e_enc;
      logic       e_vld;
      logic [1:0] e_rdy;
      logic       e_busy;
      @(posedge clk);
      #1;
      en_r       = ($urandom_range(0, 9) != 0);
      rdy_r      = ($urandom_range(0, 3) != 0);
      enable     = en_r;
      enc_in_rdy = rdy_r;
      req_vld    = {p_vld[1], p_vld[0]};
      req_data   = {p_sym[1], p_sym[0]};
      #4;
      if (owner < 0) begin
        e_enc = 2'd0; e_vld = 1'b0; e_rdy = 2'b00; e_busy = 1'b0;
      end else if (sent < FLEN) begin
        e_enc  = p_sym[owner];
        e_vld  = p_vld[owner];
        e_rdy  = rdy_r ? (2'b01 << owner) : 2'b00;
        e_busy = 1'b1;
      end else begin
        e_enc = 2'd3; e_vld = 1'b1; e_rdy = 2'b00; e_busy = 1'b1;
      end
      chk_out("rnd", e_enc, e_vld, e_rdy, e_busy, 2'(m_last),
              16'(m_frames), m_perr);

      for (int p = 0; p < NREQ; p++) acc[p] = 1'b0;
      if (owner < 0) begin
        if (en_r) begin
          for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_last + k) % NREQ;
            if (owner < 0 && p_vld[idx]) begin
              owner  = idx;
              m_last = idx;
              sent   = 0;
            end
          end
        end
      end else if (sent < FLEN) begin
        if (p_vld[owner] && rdy_r) begin
          if (p_sym[owner] == 2'd3) m_perr = 1'b1;
          acc[owner] = 1'b1;
          sent++;
        end
      end else if (rdy_r) begin
        m_frames = (m_frames + 1) % 65536;
        owner    = -1;
      end
      for (int p = 0; p < NREQ; p++) begin
        if (acc[p] || !p_vld[p]) begin
          p_vld[p] = ($urandom_range(0, 9) < 7);
          p_sym[p] = rand_sym();
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rle1_enc_sched.md
Name: rle1_enc_sched

Overview:
- Round-robin frame scheduler that shares one rle1_enc instance between NREQ symbol producers.
- Grants the encoder input to one producer for a whole frame of FRAME_LEN 2-bit symbols.
- After each frame it injects one delimiter symbol, so the encoder closes the pending run and downstream can split frames.
- Sits between the producers and rle1__input_r/_vld/_rdy. Encoder output is not touched.

Parameters:
NREQ, 2, number of requesting producers (2..4)
FRAME_LEN, 16, symbols per granted frame (2..256)
DELIM, 2'b11, reserved delimiter symbol injected after each frame

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
enable  input  1  permits new grants; sampled only in IDLE
req_data  input  2*NREQ  producer symbols; requester i on bits [2i+1:2i]
req_vld  input  NREQ  per-producer valid
req_rdy  output  NREQ  per-producer ready
enc_in  output  2  to rle1__input_r
enc_in_vld  output  1  to rle1__input_r_vld
enc_in_rdy  input  1  from rle1__input_r_rdy
grant  output  2  index of current/last granted requester
busy  output  1  high in STREAM or DELIM
frames_done  output  16  completed frames (counted at delimiter accept), wraps at 2^16
proto_err  output  1  sticky: granted producer transferred a symbol equal to DELIM

Behaviour:
- Reset values: state=IDLE; grant=NREQ-1, so requester 0 wins first; sym_cnt=0; frames_done=0; proto_err=0; req_rdy=0; enc_in_vld=0; enc_in=0; busy=0.
- Reset mid-frame aborts immediately. No delimiter is sent. The encoder shares the same reset, so its pending run is discarded too.
- IDLE:
  - If enable and any req_vld, pick the first requester with valid in the order grant+1, grant+2, ... (mod NREQ).
  - Register the pick into grant, clear sym_cnt, go to STREAM next cycle.
  - Outputs in IDLE: enc_in_vld=0, req_rdy=0.
  - The arbitration costs one bubble cycle per frame.
- STREAM: combinational passthrough for the granted requester g.
  - enc_in = req_data[g]
  - enc_in_vld = req_vld[g]
  - req_rdy[g] = enc_in_rdy; all other req_rdy = 0
  - Transfer = req_vld[g] & enc_in_rdy. Each transfer increments sym_cnt.
  - On the transfer where sym_cnt==FRAME_LEN-1, go to DELIM.
  - A granted producer that stalls (vld low) holds the grant indefinitely. There is no timeout.
  - If a transferred symbol == DELIM, set proto_err (sticky until reset). The symbol is still forwarded.
- DELIM:
  - enc_in=DELIM, enc_in_vld=1, all req_rdy=0.
  - When enc_in_rdy is high: frames_done++ (wraps), go to IDLE.
  - enc_in must stay stable while vld is high and rdy is low.
- enable:
  - Deasserting enable mid-frame does not truncate; the current frame and its delimiter complete.
  - Only new grants are blocked.
- Simultaneous events:
  - All producers valid in IDLE: strict rotation, so each gets exactly one frame per round.
  - Only one producer valid: it is regranted back-to-back, with one IDLE cycle between frames.
- Latency: first symbol of a frame can reach the encoder 1 cycle after the IDLE decision. The delimiter is presented the cycle after the last data transfer.
- Width rules:
  - sym_cnt is clog2(FRAME_LEN) bits, or 1 bit when FRAME_LEN<=2.
  - grant is 2 bits; the upper values are unused when NREQ<4.

Decomposition:
- Shared package rle1_pkg holds:
  - the symbol width constant (2)
  - the encoded token width (6)
  - the default DELIM value
  - the state enum typedef {IDLE, STREAM, DELIM}
- One natural sub-module: rle1_rr_pick, a combinational round-robin selector. Inputs: req_vld, last grant. Outputs: next grant, any-valid.
- A top-level wrapper instances rle1_enc_sched plus rle1_enc.

Test Plan:
- Reset, then req_vld=2'b01, FRAME_LEN=4, symbols 0,0,1,2, enc_in_rdy=1 -> enc_in sequence 0,0,1,2,3 (DELIM); busy high for 5 cycles; frames_done=1; grant=0.
- Both producers valid continuously, enable=1 -> grants alternate 0,1,0,1; each frame is 4 symbols plus DELIM; frames_done=4 after 4 frames; one IDLE cycle between frames.
- enc_in_rdy held low for 3 cycles during STREAM, then during DELIM -> enc_in/enc_in_vld stable; req_rdy[g]=0 while stalled; no symbol lost or duplicated; sym_cnt unchanged.
- Clear enable after the 2nd symbol of a frame -> frame completes, DELIM sent, then IDLE with no further grant while req_vld stays high; re-enabling resumes with the next requester in rotation.
- Granted producer sends symbol 3 mid-frame -> proto_err=1 and stays 1; symbol forwarded unchanged; frame still terminates with DELIM.
- Assert reset in the cycle after the 2nd STREAM transfer -> next cycle: state IDLE, busy=0, enc_in_vld=0, frames_done=0, grant=NREQ-1, proto_err=0.
